key_sequence_matcher: RTL and testbench
=======================================

# key_sequence_matcher

Multi-pattern successor to the single-sequence mode detector. It watches the debounced, priority-resolved live key stream from the piano front end. It matches up to NUM_SEQ independently programmable key sequences in parallel and reports which one completed with a one-cycle pulse plus a pattern index. It sits between the key scanner/priority encoder and the mode controller, which uses match_id to select practice, playback or demo modes.

## Interface
- NUM_SEQ, 4: number of pattern slots (1..8).
- MAX_LEN, 8: maximum keys per pattern (7..16).
- KEY_W, 4: key ID width; ID 0 means no key.
- CLK_FREQ_HZ, 50_000_000: clock frequency.
- TIMEOUT_MS, 2000: maximum gap between keys of a sequence; TIMEOUT_CYCLES = TIMEOUT_MS*(CLK_FREQ_HZ/1000).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- current_live_key_id  in  KEY_W  current key ID, 0 = none.
- current_live_key_pressed  in  1  a key is held.
- cfg_we  in  1  one-cycle write strobe for pattern memory.
- cfg_slot  in  clog2(NUM_SEQ)  pattern slot being written.
- cfg_pos  in  clog2(MAX_LEN)  position within the pattern.
- cfg_key  in  KEY_W  key ID written at cfg_pos.
- cfg_len_we  in  1  one-cycle strobe to write a slot length.
- cfg_len  in  clog2(MAX_LEN+1)  new length; 0 disables the slot.
- match_valid  out  1  one-cycle pulse when a pattern completes.
- match_id  out  clog2(NUM_SEQ)  completed slot; valid with match_valid, held until the next match.
- seq_busy  out  1  high while any slot has a nonzero progress index.

## Operation
- Key event: current_live_key_pressed=1, current_live_key_id≠0, and current_live_key_id≠last_key.
  - last_key loads the ID while a nonzero key is pressed.
  - last_key loads 0 when current_live_key_pressed=0.
  - A held key produces exactly one event.
  - Changing directly from key A to key B is a new event.
- Per-slot state:
  - pattern[MAX_LEN] of KEY_W bits.
  - len register.
  - progress index idx, range 0..MAX_LEN-1.
- On a key event, each enabled slot (len≠0) updates independently:
  - key == pattern[idx] and idx == len-1 → slot completes; idx←0.
  - key == pattern[idx] and idx < len-1 → idx←idx+1.
  - mismatch and key == pattern[0] → idx←1, or completes immediately if len==1.
  - mismatch otherwise → idx←0.
- Completion:
  - If one or more slots complete on the same event, match_valid←1 and match_id←lowest completing slot.
  - After any completion, every slot's idx←0, so sequences do not chain through a shared tail.
- Timeout:
  - Counter clears on every key event and counts while seq_busy=1.
  - When the counter reaches TIMEOUT_CYCLES-1, all idx←0 and the counter←0.
  - The counter holds at 0 while seq_busy=0.
- Configuration:
  - cfg_we writes pattern[cfg_slot][cfg_pos]←cfg_key.
  - cfg_len_we writes len[cfg_slot]←min(cfg_len, MAX_LEN).
  - Either write forces idx of that slot to 0 in the same cycle. The write wins over a simultaneous key event for that slot only; other slots process the event normally using their unchanged contents.
  - cfg_pos ≥ MAX_LEN is ignored.
- Reset contents:
  - Slot 0 = 2,3,1,7,6,1,6 with len 7 (practice-mode sequence).
  - All other slots have len 0 and pattern 0.
- Disabled slots (len 0) never advance and never match.

## Timing
- Reset values: match_valid 0, match_id 0, seq_busy 0, all idx 0, last_key 0, timeout counter 0, patterns and lengths per the reset contents above.
- Key event detected from inputs at clock edge N → idx updates and match_valid/match_id are registered at edge N; the pulse is visible for the cycle after N.
- match_valid is high for exactly one cycle per completion.
- seq_busy is registered and reflects the idx values after each edge.
- A config write at edge N affects the matching of events at edge N+1 onward.
- Timeout fires TIMEOUT_CYCLES cycles after the last event, with no event in between.
- If a timeout and a key event occur on the same edge, the event wins: it is evaluated against the current idx and the counter clears.
- Asserting rst_n mid-sequence clears progress immediately (asynchronously); the pattern memory returns to the reset contents.

## Test plan
- Reset, then key events 2,3,1,7,6,1,6 with each key released between presses → one match_valid pulse with match_id=0, seq_busy=0 afterwards.
- Hold key 2 for 100 cycles, then 3,1,7,6,1,6 → exactly one match; the held key is counted once.
- With TIMEOUT_MS overridden to a small value, press 2,3,1, wait TIMEOUT_CYCLES, then 7,6,1,6 → no match, seq_busy falls at the timeout.
- Program slot 1 as 5,5 (len 2) and slot 2 as 5 (len 1), press 5 → match_id=2; press 5 again → match_id=2 again, because all idx cleared after the first completion.
- Enter 2,3,2,3,1,7,6,1,6 → the mismatch restart path gives idx=1 at the second 2, and a match is reported at the final 6.
- Issue cfg_len_we to slot 0 with len 0 on the same edge as the 4th key of the sequence → slot 0 idx clears and no match occurs; the remaining keys also produce no match.

Source files
------------

// File: rtl/key_seq_if.sv
// Live key stream, pattern configuration and match report between the
// key front end and the key_sequence_matcher.
interface key_seq_if #(
  parameter int unsigned NUM_SEQ = 4,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned KEY_W   = 4
);
  localparam int unsigned SLOT_W = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;
  localparam int unsigned POS_W  = $clog2(MAX_LEN);
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);

  logic [KEY_W-1:0]  current_live_key_id;
  logic              current_live_key_pressed;
  logic              cfg_we;
  logic [SLOT_W-1:0] cfg_slot;
  logic [POS_W-1:0]  cfg_pos;
  logic [KEY_W-1:0]  cfg_key;
  logic              cfg_len_we;
  logic [LEN_W-1:0]  cfg_len;
  logic              match_valid;
  logic [SLOT_W-1:0] match_id;
  logic              seq_busy;

  modport master (
    output current_live_key_id, current_live_key_pressed,
    output cfg_we, cfg_slot, cfg_pos, cfg_key, cfg_len_we, cfg_len,
    input  match_valid, match_id, seq_busy
  );

  modport slave (
    input  current_live_key_id, current_live_key_pressed,
    input  cfg_we, cfg_slot, cfg_pos, cfg_key, cfg_len_we, cfg_len,
    output match_valid, match_id, seq_busy
  );
endinterface

// File: rtl/key_sequence_matcher.sv
// Matches up to NUM_SEQ programmable key sequences in parallel on the live key
// stream and reports the lowest completing slot with a one-cycle pulse.
module key_sequence_matcher #(
  parameter int unsigned NUM_SEQ     = 4,
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned KEY_W       = 4,
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TIMEOUT_MS  = 2000
) (
  input logic     clk,
  input logic     rst_n,
  key_seq_if.slave bus
);
  localparam int unsigned SLOT_W         = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;
  localparam int unsigned POS_W          = $clog2(MAX_LEN);
  localparam int unsigned LEN_W          = $clog2(MAX_LEN + 1);
  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_MS * (CLK_FREQ_HZ / 1000);
  localparam int unsigned TO_LAST        = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned CNT_W          = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

  typedef logic [KEY_W-1:0] key_t;
  typedef logic [POS_W-1:0] idx_t;
  typedef logic [LEN_W-1:0] len_t;

  key_t              pat_q [NUM_SEQ][MAX_LEN];
  key_t              pat_d [NUM_SEQ][MAX_LEN];
  len_t              len_q [NUM_SEQ];
  len_t              len_d [NUM_SEQ];
  idx_t              idx_q [NUM_SEQ];
  idx_t              idx_d [NUM_SEQ];
  key_t              last_key_q, last_key_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              match_valid_q, match_valid_d;
  logic [SLOT_W-1:0] match_id_q, match_id_d;
  logic              busy_q, busy_d;
  logic              key_evt_c;
  key_t              key_c;
  logic [NUM_SEQ-1:0] done_c;

  // Power-on pattern: slot 0 holds the practice-mode sequence 2,3,1,7,6,1,6.
  function automatic key_t rst_key(input int s, input int p);
    key_t k;
    k = '0;
    if (s == 0) begin
      case (p)
        0:       k = KEY_W'(2);
        1:       k = KEY_W'(3);
        2:       k = KEY_W'(1);
        3:       k = KEY_W'(7);
        4:       k = KEY_W'(6);
        5:       k = KEY_W'(1);
        6:       k = KEY_W'(6);
        default: k = '0;
      endcase
    end
    return k;
  endfunction

  function automatic len_t rst_len(input int s);
    return (s == 0) ? LEN_W'(7) : '0;
  endfunction

  always_comb begin
    pat_d         = pat_q;
    len_d         = len_q;
    idx_d         = idx_q;
    last_key_d    = last_key_q;
    cnt_d         = cnt_q;
    match_valid_d = 1'b0;
    match_id_d    = match_id_q;
    busy_d        = 1'b0;
    done_c        = '0;
    key_c         = bus.current_live_key_id;
    key_evt_c     = bus.current_live_key_pressed && (key_c != '0) && (key_c != last_key_q);

    if (!bus.current_live_key_pressed) begin
      last_key_d = '0;
    end else if (key_c != '0) begin
      last_key_d = key_c;
    end

    // A key event outranks a coincident timeout and restarts the gap counter.
    if (key_evt_c) begin
      cnt_d = '0;
      for (int s = 0; s < int'(NUM_SEQ); s++) begin
        if (len_q[s] == '0) begin
          idx_d[s] = '0;
        end else if (key_c == pat_q[s][idx_q[s]]) begin
          if (LEN_W'(idx_q[s]) == len_q[s] - LEN_W'(1)) begin
            done_c[s] = 1'b1;
            idx_d[s]  = '0;
          end else begin
            idx_d[s] = idx_q[s] + POS_W'(1);
          end
        end else if (key_c == pat_q[s][0]) begin
          if (len_q[s] == LEN_W'(1)) begin
            done_c[s] = 1'b1;
            idx_d[s]  = '0;
          end else begin
            idx_d[s] = POS_W'(1);
          end
        end else begin
          idx_d[s] = '0;
        end
      end
    end else if (busy_q) begin
      if (cnt_q == CNT_W'(TO_LAST)) begin
        cnt_d = '0;
        for (int s = 0; s < int'(NUM_SEQ); s++) idx_d[s] = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end

    // Config writes override the event for the addressed slot only.
    if (bus.cfg_we && (32'(bus.cfg_slot) < NUM_SEQ) && (32'(bus.cfg_pos) < MAX_LEN)) begin
      pat_d[bus.cfg_slot][bus.cfg_pos] = bus.cfg_key;
      idx_d[bus.cfg_slot]              = '0;
      done_c[bus.cfg_slot]             = 1'b0;
    end
    if (bus.cfg_len_we && (32'(bus.cfg_slot) < NUM_SEQ)) begin
      len_d[bus.cfg_slot]  = (32'(bus.cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : bus.cfg_len;
      idx_d[bus.cfg_slot]  = '0;
      done_c[bus.cfg_slot] = 1'b0;
    end

    for (int s = int'(NUM_SEQ) - 1; s >= 0; s--) begin
      if (done_c[s]) match_id_d = SLOT_W'(s);
    end
    // Any completion restarts every slot so patterns never chain through a shared tail.
    if (|done_c) begin
      match_valid_d = 1'b1;
      for (int s = 0; s < int'(NUM_SEQ); s++) idx_d[s] = '0;
    end

    for (int s = 0; s < int'(NUM_SEQ); s++) begin
      if (idx_d[s] != '0) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(NUM_SEQ); s++) begin
        for (int p = 0; p < int'(MAX_LEN); p++) pat_q[s][p] <= rst_key(s, p);
        len_q[s] <= rst_len(s);
        idx_q[s] <= '0;
      end
      last_key_q    <= '0;
      cnt_q         <= '0;
      match_valid_q <= 1'b0;
      match_id_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      pat_q         <= pat_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      last_key_q    <= last_key_d;
      cnt_q         <= cnt_d;
      match_valid_q <= match_valid_d;
      match_id_q    <= match_id_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.match_valid = match_valid_q;
  assign bus.match_id    = match_id_q;
  assign bus.seq_busy    = busy_q;

endmodule

// File: tb/tb_key_sequence_matcher.sv
// Directed bench for key_sequence_matcher: reset pattern, held keys, timeout,
// slot programming, restart path, same-edge config and async reset.
module tb_key_sequence_matcher;
  localparam int unsigned NUM_SEQ = 4;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned KEY_W   = 4;
  localparam int unsigned TO_CYC  = 200;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   n_match;
  int   last_id;
  int   base;

  key_seq_if #(.NUM_SEQ(NUM_SEQ), .MAX_LEN(MAX_LEN), .KEY_W(KEY_W)) bus ();

  key_sequence_matcher #(
    .NUM_SEQ(NUM_SEQ), .MAX_LEN(MAX_LEN), .KEY_W(KEY_W),
    .CLK_FREQ_HZ(1000), .TIMEOUT_MS(TO_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count match pulses on the falling edge, away from the update edge.
  always @(negedge clk) begin
    if (bus.match_valid === 1'b1) begin
      n_match = n_match + 1;
      last_id = int'(bus.match_id);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic tap(input int k);
    step();
    bus.current_live_key_id      = KEY_W'(k);
    bus.current_live_key_pressed = 1'b1;
    step();
    bus.current_live_key_id      = '0;
    bus.current_live_key_pressed = 1'b0;
    step();
  endtask

  task automatic tap_seq(input int k0, input int k1, input int k2, input int k3,
                         input int k4, input int k5, input int k6);
    tap(k0); tap(k1); tap(k2); tap(k3); tap(k4); tap(k5); tap(k6);
  endtask

  task automatic cfg_pat(input int slot, input int pos, input int key);
    step();
    bus.cfg_we   = 1'b1;
    bus.cfg_slot = 2'(slot);
    bus.cfg_pos  = 3'(pos);
    bus.cfg_key  = KEY_W'(key);
    step();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic cfg_length(input int slot, input int len);
    step();
    bus.cfg_len_we = 1'b1;
    bus.cfg_slot   = 2'(slot);
    bus.cfg_len    = 4'(len);
    step();
    bus.cfg_len_we = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_match = 0; last_id = -1;
    rst_n = 1'b0;
    bus.current_live_key_id = '0; bus.current_live_key_pressed = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_len_we = 1'b0;
    bus.cfg_slot = '0; bus.cfg_pos = '0; bus.cfg_key = '0; bus.cfg_len = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_valid", 32'(bus.match_valid), 0);
    check("rst_id", 32'(bus.match_id), 0);
    check("rst_busy", 32'(bus.seq_busy), 0);

    // Reset pattern with releases between presses
    tap(2); tap(3); tap(1); tap(7); tap(6); tap(1);
    check("basic_busy_mid", 32'(bus.seq_busy), 1);
    check("basic_nomatch_mid", 32'(n_match), 0);
    tap(6);
    check("basic_match", 32'(n_match), 1);
    check("basic_id", 32'(last_id), 0);
    check("basic_busy_after", 32'(bus.seq_busy), 0);
    check("basic_pulse_1cyc", 32'(bus.match_valid), 0);

    // Direct change 2 -> 3 -> 1 without release gives three events
    step();
    bus.current_live_key_pressed = 1'b1;
    bus.current_live_key_id = 4'd2; step();
    bus.current_live_key_id = 4'd3; step();
    bus.current_live_key_id = 4'd1; step();
    bus.current_live_key_pressed = 1'b0; bus.current_live_key_id = '0;
    tap(7); tap(6); tap(1); tap(6);
    check("direct_change_match", 32'(n_match), 2);

    // Holding key 3 for 100 cycles counts once
    tap(2);
    step();
    bus.current_live_key_id = 4'd3; bus.current_live_key_pressed = 1'b1;
    repeat (100) step();
    check("hold_busy", 32'(bus.seq_busy), 1);
    bus.current_live_key_id = '0; bus.current_live_key_pressed = 1'b0;
    tap(1); tap(7); tap(6); tap(1); tap(6);
    check("hold_match", 32'(n_match), 3);
    check("hold_id", 32'(last_id), 0);

    // Timeout: last event at edge E, progress cleared exactly at E+TO_CYC
    tap(2); tap(3); tap(1);
    repeat (TO_CYC - 2) step();
    check("to_busy_before", 32'(bus.seq_busy), 1);
    step();
    check("to_busy_after", 32'(bus.seq_busy), 0);
    tap(7); tap(6); tap(1); tap(6);
    check("to_nomatch", 32'(n_match), 3);

    // Restart path: second 2 mismatches pattern[2] but equals pattern[0]
    tap(2); tap(3); tap(2);
    check("restart_busy", 32'(bus.seq_busy), 1);
    tap(3); tap(1); tap(7); tap(6); tap(1); tap(6);
    check("restart_match", 32'(n_match), 4);

    // Slot 1 = 5,5 ; slot 2 = 5 ; lowest completing slot wins, all idx cleared
    cfg_pat(1, 0, 5); cfg_pat(1, 1, 5); cfg_length(1, 2);
    cfg_pat(2, 0, 5); cfg_length(2, 1);
    tap(5);
    check("s2_first_match", 32'(n_match), 5);
    check("s2_first_id", 32'(last_id), 2);
    tap(5);
    check("s2_second_match", 32'(n_match), 6);
    check("s2_second_id", 32'(last_id), 2);
    check("s2_busy", 32'(bus.seq_busy), 0);
    cfg_length(2, 0);
    tap(5); tap(5);
    check("s1_match", 32'(n_match), 7);
    check("s1_id", 32'(last_id), 1);

    // Length clamp: 15 becomes MAX_LEN, so eight 9s are required
    for (int p = 0; p < int'(MAX_LEN); p++) cfg_pat(3, p, 9);
    cfg_length(3, 15);
    base = n_match;
    for (int i = 0; i < 7; i++) begin
      tap(9);
      step();
      bus.current_live_key_id = '0;
    end
    check("clamp_nomatch7", 32'(n_match - base), 0);
    check("clamp_busy7", 32'(bus.seq_busy), 1);
    tap(9);
    check("clamp_match8", 32'(n_match - base), 1);
    check("clamp_id", 32'(last_id), 3);

    // Disable slot 0 on the same edge as the 4th key
    base = n_match;
    tap(2); tap(3); tap(1);
    step();
    bus.current_live_key_id = 4'd7; bus.current_live_key_pressed = 1'b1;
    bus.cfg_len_we = 1'b1; bus.cfg_slot = 2'd0; bus.cfg_len = 4'd0;
    step();
    bus.cfg_len_we = 1'b0;
    bus.current_live_key_id = '0; bus.current_live_key_pressed = 1'b0;
    check("samedge_busy", 32'(bus.seq_busy), 0);
    tap(6); tap(1); tap(6);
    check("samedge_nomatch", 32'(n_match - base), 0);
    cfg_length(0, 7);
    tap_seq(2, 3, 1, 7, 6, 1, 6);
    check("reenable_match", 32'(n_match - base), 1);
    check("reenable_id", 32'(last_id), 0);

    // Async reset mid-sequence clears progress and restores pattern memory
    tap(2); tap(3);
    check("prereset_busy", 32'(bus.seq_busy), 1);
    rst_n = 1'b0;
    #1;
    check("async_busy", 32'(bus.seq_busy), 0);
    step();
    rst_n = 1'b1;
    step();
    base = n_match;
    tap(9);
    check("reset_slot3_len", 32'(bus.seq_busy), 0);
    tap(5); tap(5);
    check("reset_slot1_len", 32'(n_match - base), 0);
    tap_seq(2, 3, 1, 7, 6, 1, 6);
    check("postreset_match", 32'(n_match - base), 1);
    check("postreset_id", 32'(last_id), 0);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
